// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM-like port arbiter: access sizes, master ids,
// FSM states and the bundle of address-phase fields a master presents.
package sram_port_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/sram_port_arbiter_id_fifo.sv
// In-order 1-bit id FIFO: remembers which master owns each outstanding
// transaction so responses can be routed back in issue order.
module sram_port_arbiter_id_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_reg;
  logic [DEPTH-1:0] mem_we;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign mem_we[gi] = push_en && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_we[i]) mem_reg[i] <= push_id;
      end
      // pointers are exactly log2(DEPTH) wide, so they wrap on their own
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master (inst/data) arbiter onto one SRAM-like bus: data has fixed
// priority, a stalled grant is locked until accepted, responses return in order.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m0_req,
  input  logic             m0_wr,
  input  logic [1:0]       m0_size,
  input  logic [3:0]       m0_wstrb,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_addr_ok,
  output logic             m0_data_ok,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [1:0]       m1_size,
  input  logic [3:0]       m1_wstrb,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_addr_ok,
  output logic             m1_data_ok,
  output logic [31:0]      m1_rdata,
  output logic             s_req,
  output logic             s_wr,
  output logic [1:0]       s_size,
  output logic [3:0]       s_wstrb,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_wdata,
  input  logic             s_addr_ok,
  input  logic             s_data_ok,
  input  logic [31:0]      s_rdata,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             err_spurious
);

  state_t      state_reg, state_next;
  logic        lock_id_reg, lock_id_next;
  logic        err_reg, err_next;
  logic        grant_id;
  logic        accept;
  logic        pop;
  logic        fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  req_fields_t m0_fields, m1_fields, s_fields;

  assign m0_fields = '{wr: m0_wr, size: m0_size, wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
  assign m1_fields = '{wr: m1_wr, size: m1_size, wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

  sram_port_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant_id),
    .pop     (pop),
    .head    (fifo_head),
    .count   (outstanding_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      lock_id_reg <= ID_INST;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lock_id_reg <= lock_id_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lock_id_next = lock_id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (s_req && !s_addr_ok) begin
          state_next   = ST_LOCK;
          lock_id_next = grant_id;
        end
      end
      ST_LOCK: begin
        if (s_addr_ok) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_id = ID_INST;
    s_req    = 1'b0;
    if (state_reg == ST_LOCK) begin
      grant_id = lock_id_reg;
      s_req    = 1'b1;
    end else if (!fifo_full) begin
      grant_id = m1_req ? ID_DATA : ID_INST;
      s_req    = m1_req | m0_req;
    end
    // outputs are forced low while reset is asserted, without waiting for a clock
    s_req    = s_req & resetn;
    s_fields = s_req ? ((grant_id == ID_DATA) ? m1_fields : m0_fields) : '0;
    s_wr     = s_fields.wr;
    s_size   = s_fields.size;
    s_wstrb  = s_fields.wstrb;
    s_addr   = s_fields.addr;
    s_wdata  = s_fields.wdata;

    accept     = s_req & s_addr_ok;
    m0_addr_ok = accept & (grant_id == ID_INST);
    m1_addr_ok = accept & (grant_id == ID_DATA);

    // emptiness is start-of-cycle, so a same-cycle push never answers this response
    pop        = s_data_ok & ~fifo_empty & resetn;
    m0_data_ok = pop & (fifo_head == ID_INST);
    m1_data_ok = pop & (fifo_head == ID_DATA);
    m0_rdata   = resetn ? s_rdata : '0;
    m1_rdata   = resetn ? s_rdata : '0;

    err_next     = err_reg | (s_data_ok & fifo_empty);
    err_spurious = err_reg;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven checks of arbitration, locking, fullness, ordering,
// spurious responses and asynchronous reset of sram_port_arbiter.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam logic [31:0] M0_ADDR  = 32'h1C00_0000;
  localparam logic [31:0] M0_WDATA = 32'h1234_5678;
  localparam logic [31:0] M1_ADDR  = 32'h8000_1002;
  localparam logic [31:0] M1_WDATA = 32'hA5A5_5A5A;

  logic        clk, resetn;
  logic        m0_req, m1_req, s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  outstanding_cnt;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(1'b0), .m0_size(SIZE_W), .m0_wstrb(4'h0),
    .m0_addr(M0_ADDR), .m0_wdata(M0_WDATA),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(1'b1), .m1_size(SIZE_B), .m1_wstrb(4'b0100),
    .m1_addr(M1_ADDR), .m1_wdata(M1_WDATA),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding_cnt(outstanding_cnt), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req, m1_req, s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        e_sreq, e_gnt, e_a0, e_a1, e_d0, e_d1;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic r0, logic r1, logic aok, logic dok, logic [31:0] rd,
                              logic sreq, logic gnt, logic a0, logic a1, logic d0, logic d1,
                              logic [2:0] cnt, logic err);
    vec_t v;
    v.m0_req = r0; v.m1_req = r1; v.s_addr_ok = aok; v.s_data_ok = dok; v.s_rdata = rd;
    v.e_sreq = sreq; v.e_gnt = gnt; v.e_a0 = a0; v.e_a1 = a1; v.e_d0 = d0; v.e_d1 = d1;
    v.e_cnt = cnt; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic aok, input logic dok,
                       input logic [31:0] rd);
    @(negedge clk);
    m0_req = r0; m1_req = r1; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    #1;
  endtask

  task automatic chk_fields(input string name, input int idx, input logic sreq, input logic gnt);
    chk({name, "_s_req"}, idx, 32'(s_req), 32'(sreq));
    chk({name, "_s_addr"}, idx, s_addr, !sreq ? 32'h0 : (gnt ? M1_ADDR : M0_ADDR));
    chk({name, "_s_wdata"}, idx, s_wdata, !sreq ? 32'h0 : (gnt ? M1_WDATA : M0_WDATA));
    chk({name, "_s_ctl"}, idx, {25'h0, s_wr, s_size, s_wstrb},
        !sreq ? 32'h0 : (gnt ? {25'h0, 1'b1, SIZE_B, 4'b0100} : {25'h0, 1'b0, SIZE_W, 4'h0}));
  endtask

  int q[$];
  logic [9:0] pattern;

  initial begin
    // idx: r0 r1 aok dok rdata | sreq gnt a0 a1 d0 d1 cnt err
    vecs[0]  = mk(1,1,1,0,32'h0,          1,1,0,1,0,0,3'd0,0); // both request: data wins
    vecs[1]  = mk(1,0,1,0,32'h0,          1,0,1,0,0,0,3'd1,0); // inst next
    vecs[2]  = mk(0,0,0,1,32'h1111_1111,  0,0,0,0,0,1,3'd2,0); // first response -> m1
    vecs[3]  = mk(0,0,0,1,32'h2222_2222,  0,0,0,0,1,0,3'd1,0); // second -> m0
    vecs[4]  = mk(1,0,0,0,32'h0,          1,0,0,0,0,0,3'd0,0); // stall -> LOCK on m0
    vecs[5]  = mk(1,1,0,0,32'h0,          1,0,0,0,0,0,3'd0,0); // m1 rises, lock holds m0
    vecs[6]  = mk(1,1,0,0,32'h0,          1,0,0,0,0,0,3'd0,0);
    vecs[7]  = mk(1,1,1,0,32'h0,          1,0,1,0,0,0,3'd0,0); // m0 accepted in cycle 4
    vecs[8]  = mk(0,1,1,0,32'h0,          1,1,0,1,0,0,3'd1,0); // then m1
    vecs[9]  = mk(0,0,0,1,32'h3333_3333,  0,0,0,0,1,0,3'd2,0);
    vecs[10] = mk(0,0,0,1,32'h4444_4444,  0,0,0,0,0,1,3'd1,0);
    vecs[11] = mk(1,0,1,0,32'h0,          1,0,1,0,0,0,3'd0,0); // fill to 4
    vecs[12] = mk(1,0,1,0,32'h0,          1,0,1,0,0,0,3'd1,0);
    vecs[13] = mk(1,0,1,0,32'h0,          1,0,1,0,0,0,3'd2,0);
    vecs[14] = mk(1,0,1,0,32'h0,          1,0,1,0,0,0,3'd3,0);
    vecs[15] = mk(1,0,1,0,32'h0,          0,0,0,0,0,0,3'd4,0); // full: no request
    vecs[16] = mk(1,0,1,1,32'h5555_5555,  0,0,0,0,1,0,3'd4,0); // same-cycle pop frees nothing
    vecs[17] = mk(1,0,1,0,32'h0,          1,0,1,0,0,0,3'd3,0); // slot free -> s_req back
    vecs[18] = mk(0,0,0,1,32'h6,          0,0,0,0,1,0,3'd4,0); // drain
    vecs[19] = mk(0,0,0,1,32'h7,          0,0,0,0,1,0,3'd3,0);
    vecs[20] = mk(0,0,0,1,32'h8,          0,0,0,0,1,0,3'd2,0);
    vecs[21] = mk(0,0,0,1,32'h9,          0,0,0,0,1,0,3'd1,0);
    vecs[22] = mk(0,0,0,1,32'hDEAD_BEEF,  0,0,0,0,0,0,3'd0,0); // spurious
    vecs[23] = mk(0,0,0,0,32'h0,          0,0,0,0,0,0,3'd0,1); // sticky error
    vecs[24] = mk(0,1,1,0,32'h0,          1,1,0,1,0,0,3'd0,1);
    vecs[25] = mk(0,0,0,1,32'hA,          0,0,0,0,0,1,3'd1,1);

    resetn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b0;
    s_rdata = 32'h0;
    #3;
    chk_fields("reset", 0, 1'b0, 1'b0);
    chk("reset_addr_ok", 0, {30'h0, m1_addr_ok, m0_addr_ok}, 32'h0);
    chk("reset_cnt", 0, 32'(outstanding_cnt), 32'h0);
    chk("reset_err", 0, 32'(err_spurious), 32'h0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].m0_req, vecs[i].m1_req, vecs[i].s_addr_ok, vecs[i].s_data_ok, vecs[i].s_rdata);
      chk_fields("vec", i, vecs[i].e_sreq, vecs[i].e_gnt);
      chk("vec_addr_ok", i, {30'h0, m1_addr_ok, m0_addr_ok}, {30'h0, vecs[i].e_a1, vecs[i].e_a0});
      chk("vec_data_ok", i, {30'h0, m1_data_ok, m0_data_ok}, {30'h0, vecs[i].e_d1, vecs[i].e_d0});
      chk("vec_cnt", i, 32'(outstanding_cnt), 32'(vecs[i].e_cnt));
      chk("vec_err", i, 32'(err_spurious), 32'(vecs[i].e_err));
      chk("vec_rdata", i, m0_rdata ^ m1_rdata ^ s_rdata, vecs[i].s_rdata);
      $display("vec %0d: s_req=%b s_addr=%h addr_ok=%b%b data_ok=%b%b cnt=%0d err=%b",
               i, s_req, s_addr, m1_addr_ok, m0_addr_ok, m1_data_ok, m0_data_ok,
               outstanding_cnt, err_spurious);
    end

    // Simultaneous push and pop with cnt = 2, ids wrapping around the FIFO
    drive(1, 0, 1, 0, 32'h0);
    chk("pre_a0", 0, 32'(m0_addr_ok), 32'h1);
    q.push_back(0);
    drive(0, 1, 1, 0, 32'h0);
    chk("pre_a1", 1, 32'(m1_addr_ok), 32'h1);
    q.push_back(1);
    pattern = 10'b1101001011;
    for (int i = 0; i < 10; i++) begin
      drive(!pattern[i], pattern[i], 1, 1, 32'(i));
      chk("pp_cnt", i, 32'(outstanding_cnt), 32'd2);
      chk("pp_addr_ok", i, {30'h0, m1_addr_ok, m0_addr_ok}, pattern[i] ? 32'h2 : 32'h1);
      chk("pp_data_ok", i, {30'h0, m1_data_ok, m0_data_ok}, (q[0] == 1) ? 32'h2 : 32'h1);
      $display("pp %0d: issue=%0d expect_resp=%0d data_ok=%b%b cnt=%0d",
               i, pattern[i], q[0], m1_data_ok, m0_data_ok, outstanding_cnt);
      void'(q.pop_front());
      q.push_back(int'(pattern[i]));
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 32'h0);
      chk("drain_data_ok", i, {30'h0, m1_data_ok, m0_data_ok}, (q[0] == 1) ? 32'h2 : 32'h1);
      void'(q.pop_front());
    end

    // Asynchronous reset while locked with three outstanding
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 32'h0);
      chk("rst_fill_cnt", i, 32'(outstanding_cnt), 32'(i));
    end
    drive(1, 0, 0, 0, 32'h0);
    chk("rst_lock_req", 0, 32'(s_req), 32'h1);
    drive(1, 1, 0, 0, 32'h0);
    chk_fields("rst_locked", 0, 1'b1, 1'b0);
    chk("rst_locked_cnt", 0, 32'(outstanding_cnt), 32'd3);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_s_req", 0, 32'(s_req), 32'h0);
    chk("async_rst_cnt", 0, 32'(outstanding_cnt), 32'h0);
    chk("async_rst_err", 0, 32'(err_spurious), 32'h0);
    $display("async reset: s_req=%b cnt=%0d err=%b", s_req, outstanding_cnt, err_spurious);
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 1, 1, 0, 32'h0);
    chk("post_rst_grant", 0, {30'h0, m1_addr_ok, m0_addr_ok}, 32'h2);
    drive(1, 0, 1, 0, 32'h0);
    chk("post_rst_cnt", 0, 32'(outstanding_cnt), 32'd1);
    chk("post_rst_a0", 0, 32'(m0_addr_ok), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU's instruction requester (port 0, the IF stage) and data requester (port 1, the MEM stage).
- Sits between mycpu's inst_sram_*/data_sram_* buses and the single downstream SRAM-like bus, ahead of the AXI bridge.
- Arbitrates address phases, holds the grant until the handshake completes, and tracks outstanding transactions in order so each data_ok/rdata returns to the master that issued the request.

Parameters:
- MAX_OUTSTANDING, 4, depth of the in-order ID FIFO (power of two, 2..16).
- CNT_W, 3, width of outstanding_cnt; must be log2(MAX_OUTSTANDING)+1.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- m0_req / m1_req  input  1  master request (0 = inst, 1 = data)
- m0_wr / m1_wr  input  1  write when 1
- m0_size / m1_size  input  2  0 = byte, 1 = half, 2 = word
- m0_wstrb / m1_wstrb  input  4  byte write strobes
- m0_addr / m1_addr  input  32  address
- m0_wdata / m1_wdata  input  32  write data
- m0_addr_ok / m1_addr_ok  output  1  address accepted for this master
- m0_data_ok / m1_data_ok  output  1  response for this master
- m0_rdata / m1_rdata  output  32  read data (pass-through of s_rdata)
- s_req  output  1  downstream request
- s_wr  output  1  downstream write flag
- s_size  output  2  downstream size
- s_wstrb  output  4  downstream strobes
- s_addr  output  32  downstream address
- s_wdata  output  32  downstream write data
- s_addr_ok  input  1  downstream address accepted
- s_data_ok  input  1  downstream response
- s_rdata  input  32  downstream read data
- outstanding_cnt  output  CNT_W  transactions accepted but not yet answered
- err_spurious  output  1  sticky; s_data_ok received with nothing outstanding

Behaviour:
- Reset (resetn = 0, asynchronous): FSM goes to IDLE, FIFO is emptied, outstanding_cnt = 0, err_spurious = 0. All outputs are then 0, including s_req. Outstanding transactions are dropped.
- FSM has two states, IDLE and LOCK. lock_id is a 1-bit register.
- IDLE, FIFO not full:
  - Grant goes to m1 if m1_req, otherwise to m0 if m0_req. Data has fixed priority over inst.
  - s_req = 1 and the s_* fields mux the granted master's fields, combinationally.
  - If s_addr_ok is high the same cycle: the granted master's addr_ok = 1, its id is pushed, and the FSM stays in IDLE.
  - If s_addr_ok is low: lock_id is set to the grant and the FSM goes to LOCK.
- IDLE, FIFO full: s_req = 0 and both addr_ok outputs are 0. Fullness is evaluated from start-of-cycle count; a same-cycle pop does not free a slot.
- LOCK:
  - s_req = 1 and the s_* fields come from master lock_id, regardless of the other master's req. Masters must hold req and fields stable until addr_ok.
  - On s_addr_ok: push lock_id, assert m[lock_id]_addr_ok, return to IDLE.
  - No new request can enter LOCK while the FIFO is full, because entry requires not-full and only pops occur while locked.
- addr_ok of the non-granted master is always 0.
- Response routing:
  - On s_data_ok with the FIFO non-empty: m[head]_data_ok = 1 the same cycle (combinational), and head is popped.
  - m0_rdata and m1_rdata always equal s_rdata.
- s_data_ok with the FIFO empty: ignored (no data_ok to either master) and err_spurious is set.
  - A push in the same cycle does not satisfy it; a response never completes the address phase of its own cycle.
- Simultaneous push and pop: both take effect and outstanding_cnt is unchanged.
- outstanding_cnt:
  - +1 on push only, -1 on pop only.
  - Equals the FIFO occupancy and is registered.
- FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. Full is count == MAX_OUTSTANDING.
- Latency: zero added cycles on both the address and the response path. The only state added is the lock.

Decomposition:
- Shared package: size encodings (SIZE_B = 0, SIZE_H = 1, SIZE_W = 2), master id constants (ID_INST = 0, ID_DATA = 1), FSM state constants.
- One sub-module: id_fifo, a synchronous 1-bit-wide FIFO of depth MAX_OUTSTANDING with push, pop, head, count, full and empty. It uses the same asynchronous active-low resetn.

Test Plan:
- Read, both masters in one cycle:
  - Stimulus: m0_req = m1_req = 1 in the same cycle, s_addr_ok = 1 immediately.
  - Required: s_addr = m1_addr and only m1_addr_ok pulses.
  - Next cycle: m0 is granted.
  - Then s_data_ok twice with rdata 0x11111111 then 0x22222222: m1_data_ok fires first, then m0_data_ok.
- Lock hold:
  - Stimulus: m0_req alone, s_addr_ok held low for 3 cycles; m1_req rises in cycle 2.
  - Required: s_addr stays at m0_addr 0x1C000000 throughout, and m0 gets addr_ok in cycle 4.
  - After that, m1 is granted.
- Full:
  - Stimulus: with MAX_OUTSTANDING = 4, issue 4 accepted requests and no responses.
  - Required: outstanding_cnt = 4 and s_req = 0 despite m0_req = 1.
  - Then one s_data_ok: cnt = 3 the next cycle, and s_req is reasserted that cycle.
- Simultaneous push and pop:
  - Stimulus: with cnt = 2, s_addr_ok and s_data_ok arrive in the same cycle.
  - Required: cnt stays 2 and order is preserved across pointer wrap-around over 10 mixed transactions.
- Spurious response:
  - Stimulus: s_data_ok with cnt = 0.
  - Required: no master data_ok and err_spurious = 1 (sticky).
- Reset mid-operation:
  - Stimulus: deassert resetn asynchronously while in LOCK with cnt = 3.
  - Required: s_req = 0, cnt = 0 and err_spurious = 0 immediately, without a clock edge.
